// File: rtl/exec_result_buffer_pkg.sv
// exec_result_buffer_pkg: shared types and defaults for the execute-to-writeback result buffer
package exec_result_buffer_pkg;

    localparam int EXEC_RESULT_DEPTH = 4;

    typedef logic [31:0] basic_data_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wr_en;
        basic_data_t result;
    } exec_result_entry_t;

endpackage

// File: rtl/exec_result_buffer_bypass_select.sv
// result_bypass_select: youngest occupied entry matching a source register (used with EXEC_RESULT_BYPASS_EN)
module result_bypass_select
    import exec_result_buffer_pkg::*;
#(
    parameter int DEPTH = EXEC_RESULT_DEPTH
) (
    input  exec_result_entry_t           entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic [4:0]                   rs,
    output logic                         hit,
    output basic_data_t                  data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // walk oldest to youngest so the last match seen is the youngest
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && rs != 5'd0 &&
                entries[head + PW'(i)].wr_en && entries[head + PW'(i)].rd == rs) begin
                hit  = 1'b1;
                data = entries[head + PW'(i)].result;
            end
        end
    end

endmodule

// File: rtl/exec_result_buffer.sv
// exec_result_buffer: in-order FIFO from integer execute to writeback; forwarding lookup under EXEC_RESULT_BYPASS_EN
module exec_result_buffer
    import exec_result_buffer_pkg::*;
#(
    parameter int DEPTH = EXEC_RESULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
`ifdef EXEC_RESULT_BYPASS_EN
    input  logic [4:0]                  fwd_rs,
    output logic                        fwd_hit,
    output basic_data_t                 fwd_data,
`endif
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4:0]                  in_rd,
    input  logic                        in_wr_en,
    input  basic_data_t                 in_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4:0]                  out_rd,
    output logic                        out_wr_en,
    output basic_data_t                 out_result,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    exec_result_entry_t mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic               push;
    logic               pop;

    assign in_ready   = cnt < CW'(DEPTH);
    assign out_valid  = cnt != '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign count      = cnt;
    assign out_rd     = out_valid ? mem[rd_ptr].rd     : '0;
    assign out_wr_en  = out_valid ? mem[rd_ptr].wr_en  : 1'b0;
    assign out_result = out_valid ? mem[rd_ptr].result : '0;

    // control state: reset beats flush, flush cancels any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            cnt    <= cnt + CW'(push) - CW'(pop);
        end
    end

    // entry storage; writes to x0 are demoted so they never reach the register file
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{rd: in_rd, wr_en: in_wr_en && in_rd != 5'd0, result: in_result};
    end

`ifdef EXEC_RESULT_BYPASS_EN
    result_bypass_select #(.DEPTH(DEPTH)) u_bypass (
        .entries (mem),
        .head    (rd_ptr),
        .count   (cnt),
        .rs      (fwd_rs),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );
`endif

endmodule
